// File: rtl/node_frame_streamer.sv
// node_frame_streamer
// Snapshots a packed bus of NODE_COUNT (x,y) coordinate pairs when a frame is
// requested, then streams the frozen copy out one node per valid/ready beat.
// A single request arriving mid-frame is queued; any further ones are counted
// as drops.
module node_frame_streamer #(
  parameter int NODE_COUNT = 5,
  parameter int COORD_W    = 32,
  parameter int IDX_W      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
  input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
  input  logic                          frame_req,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_W-1:0]            out_x,
  output logic [COORD_W-1:0]            out_y,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic [7:0]                    drop_count
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);

  state_t             state;
  state_t             state_nxt;
  logic               pending;
  logic               start;
  logic               hs;
  logic               last_hs;
  logic [IDX_W-1:0]   idx_nxt;
  logic [COORD_W-1:0] nxt_x;
  logic [COORD_W-1:0] nxt_y;
  logic [COORD_W-1:0] snap_x [NODE_COUNT];
  logic [COORD_W-1:0] snap_y [NODE_COUNT];

  // Drop counter sticks at its ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start   = (state == S_IDLE) && (frame_req || pending);
  assign hs      = out_valid && out_ready;
  assign last_hs = hs && (out_idx == LAST_IDX);
  assign idx_nxt = out_idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a start leaves IDLE, the final accepted beat returns.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)   state_nxt = S_SEND;
      S_SEND:  if (last_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State decode: a beat is offered for the whole time we are sending.
  always_comb begin
    out_valid = (state == S_SEND);
    busy      = (state == S_SEND);
  end

  // Frozen copy of the node bus; only a frame start may overwrite it.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < NODE_COUNT; i++) begin
        snap_x[i] <= nodes_x[i*COORD_W +: COORD_W];
        snap_y[i] <= nodes_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Select the snapshot entry for the beat that follows the current one.
  always_comb begin
    nxt_x = '0;
    nxt_y = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nxt_x = snap_x[i];
        nxt_y = snap_y[i];
      end
    end
  end

  // Beat registers, request queue and frame statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_x       <= '0;
      out_y       <= '0;
      out_idx     <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      frame_done <= last_hs;
      if (last_hs) frame_count <= frame_count + 16'd1;

      // One-deep queue; a request while already queued is a drop.
      if (start) begin
        pending <= 1'b0;
      end else if ((state == S_SEND) && frame_req) begin
        pending <= 1'b1;
        if (pending) drop_count <= sat_inc8(drop_count);
      end

      // Node 0 comes straight off the bus so it is visible the cycle after start.
      if (start) begin
        out_x     <= nodes_x[COORD_W-1:0];
        out_y     <= nodes_y[COORD_W-1:0];
        out_idx   <= '0;
        out_first <= 1'b1;
        out_last  <= 1'b0;
      end else if (hs && !last_hs) begin
        out_x     <= nxt_x;
        out_y     <= nxt_y;
        out_idx   <= idx_nxt;
        out_first <= 1'b0;
        out_last  <= (idx_nxt == LAST_IDX);
      end
    end
  end

endmodule
